// File: rtl/md_pkg.sv
// Shared op codes and FSM state encoding for the HI/LO multiply/divide unit.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } md_state_t;

endpackage

// File: rtl/md_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module md_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // The incoming remainder is always below the divisor, so a non-negative
    // trial fits in WIDTH bits and its top bit doubles as the borrow flag.
    assign w_shift = {i_rem, i_bit};
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign o_qbit  = ~w_trial[WIDTH];
    assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with HI/LO registers: one shift-add or
// restoring step per cycle on operand magnitudes, then a sign-fix/commit cycle.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import md_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    md_state_t          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed_op;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH-1:0]   w_div_rem;
    logic               w_div_qbit;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed_op = (op == MD_MULT) || (op == MD_DIV);
    assign w_mag_a     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_mag_b     = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // Multiply: LO half holds the remaining multiplier bits, HI half the
    // running partial product; the adder carry shifts back in from the top.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: HI half is the partial remainder, LO half shifts dividend bits
    // out of the top while quotient bits enter at the bottom.
    md_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
        .i_bit     (r_acc[WIDTH-1]),
        .i_divisor (r_opb),
        .o_rem     (w_div_rem),
        .o_qbit    (w_div_qbit)
    );
    assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_qbit};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quot_fix = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // NOTE: every register here, including the working datapath, is reset so
    // an aborted operation leaves no stale state; all updates use <= so each
    // always_ff reads last-cycle values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        case (op)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                r_state  <= op[1] ? S_DIV : S_MUL;
                                r_cnt    <= CNT_W'(WIDTH - 1);
                                r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                                r_opb    <= w_mag_b;
                                r_is_div <= op[1];
                                // A zero divisor keeps the all-ones quotient un-negated.
                                r_neg_q  <= w_signed_op && (a[WIDTH-1] ^ b[WIDTH-1])
                                            && (!op[1] || (b != '0));
                                r_neg_r  <= w_signed_op && a[WIDTH-1];
                            end
                            MD_MTHI: r_hi <= a;
                            MD_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= (r_state == S_DIV) ? w_div_next : w_mul_next;
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!cancel) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (WIDTH=32): vector table for mul/div results and
// latency, plus hand sequences for MTHI/MTLO, cancel, dropped starts and reset.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 with the unit idle; issues one mul/div op and checks
    // latency, the single done pulse and the committed HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                          input logic [31:0] b_i, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int busy_cycles;
        int early_done;
        busy_cycles = 0;
        early_done  = 0;
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        tick();
        start = 1'b0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            if (done) early_done++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({tag, "_early_done"}, 64'(early_done), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int cnt;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MD_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[6]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[9]  = '{MD_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[10] = '{MD_DIVU,  32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA};
        vecs[11] = '{MD_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};

        rst    = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 3'b000;
        a      = '0;
        b      = '0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // MTHI then MTLO on consecutive cycles: one edge each, never busy.
        start = 1'b1;
        op    = MD_MTHI;
        a     = 32'hAAAA0000;
        tick();
        check("mthi_hi", 64'(hi), 64'h00000000AAAA0000);
        check("mthi_busy", 64'(busy), 64'd0);
        op = MD_MTLO;
        a  = 32'h00005555;
        tick();
        start = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h0000000000005555);
        check("mtlo_hi_kept", 64'(hi), 64'h00000000AAAA0000);
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mtlo_done", 64'(done), 64'd0);

        // Reserved op code is a no-op.
        start = 1'b1;
        op    = 3'b110;
        a     = 32'h11111111;
        tick();
        start = 1'b0;
        check("noop_busy", 64'(busy), 64'd0);
        check("noop_hi", 64'(hi), 64'h00000000AAAA0000);
        check("noop_lo", 64'(lo), 64'h0000000000005555);

        // cancel with start in IDLE: the start is dropped.
        start  = 1'b1;
        cancel = 1'b1;
        op     = MD_MTHI;
        a      = 32'h22222222;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
        check("idle_cancel_hi", 64'(hi), 64'h00000000AAAA0000);
        check("idle_cancel_busy", 64'(busy), 64'd0);

        // Cancel mid-DIV at busy cycle 10 with a competing start.
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd1000;
        b     = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("cancel_pre_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        start  = 1'b1;
        op     = MD_DIVU;
        a      = 32'd9;
        b      = 32'd3;
        tick();
        cancel = 1'b0;
        start  = 1'b0;
        check("cancel_busy", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_hi", 64'(hi), 64'h00000000AAAA0000);
        check("cancel_lo", 64'(lo), 64'h0000000000005555);
        cnt = 0;
        repeat (40) begin
            tick();
            if (done || busy) cnt++;
        end
        check("cancel_quiet", 64'(cnt), 64'd0);

        run_op("divu_9_3", MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

        // start while busy is dropped: an MTHI in mid-MUL must not land.
        start = 1'b1;
        op    = MD_MULT;
        a     = 32'd3;
        b     = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        op    = MD_MTHI;
        a     = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        cnt = 0;
        while (!done && cnt < 100) begin
            cnt++;
            tick();
        end
        check("busy_start_done", 64'(done), 64'd1);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'h000000000000000F);
        tick();

        // Cancel exactly in FIX suppresses the commit.
        start = 1'b1;
        op    = MD_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        tick();
        start = 1'b0;
        repeat (32) tick();
        check("fix_pre_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("fix_cancel_busy", 64'(busy), 64'd0);
        check("fix_cancel_done", 64'(done), 64'd0);
        check("fix_cancel_hi", 64'(hi), 64'd0);
        check("fix_cancel_lo", 64'(lo), 64'h000000000000000F);
        tick();
        check("fix_cancel_done2", 64'(done), 64'd0);

        // Asynchronous reset mid-MUL clears everything immediately.
        start = 1'b1;
        op    = MD_MULTU;
        a     = 32'hFFFFFFFF;
        b     = 32'hFFFFFFFF;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        tick();
        rst = 1'b1;
        cnt = 0;
        repeat (40) begin
            tick();
            if (done || busy) cnt++;
        end
        check("rst_mid_quiet", 64'(cnt), 64'd0);
        check("rst_mid_lo_kept", 64'(lo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
